// File: rtl/counter_game.sv
// rtl/counter_game.sv - up/down play counter with win/lose scoring and auto-restart
//
// Purpose:
//    A play counter steps up or down by 1 or 2 each clock (or loads a value).
//    Reaching the all-ones value by counting up is a win; reaching zero by
//    counting down is a loss. Wins and losses are tallied in saturating score
//    counters. When either score fills, a game-over pulse reports who filled
//    and the whole game restarts on the following edge.
//
// Ports:
//    clk        in   1          clock, all state on rising edge
//    reset      in   1          synchronous, active-low
//    INIT_c     in   1          load strobe for the play counter
//    INIT_l     in   SIZE       load value
//    control    in   2          00 +1, 01 +2, 10 -1, 11 -2
//    count      out  SIZE       play counter
//    direction  out  1          1 = last counting step was up
//    WINNER     out  1          one-cycle win pulse
//    LOSER      out  1          one-cycle lose pulse
//    w_count    out  MAX_SCORE  win score (saturating)
//    l_count    out  MAX_SCORE  lose score (saturating)
//    GAMEOVER   out  1          one-cycle game-end pulse
//    WHO        out  2          01 win side, 10 lose side, 11 both; held

module counter_game #(
   parameter int SIZE      = 4,
   parameter int MAX_SCORE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 INIT_c,
   input  logic [SIZE-1:0]      INIT_l,
   input  logic [1:0]           control,
   output logic [SIZE-1:0]      count,
   output logic                 direction,
   output logic                 WINNER,
   output logic                 LOSER,
   output logic [MAX_SCORE-1:0] w_count,
   output logic [MAX_SCORE-1:0] l_count,
   output logic                 GAMEOVER,
   output logic [1:0]           WHO
);

   localparam logic [SIZE-1:0]      C_TOP = '1;
   localparam logic [MAX_SCORE-1:0] S_TOP = '1;

   logic [SIZE-1:0]      r_count;
   logic                 r_dir;
   logic                 r_winner;
   logic                 r_loser;
   logic [MAX_SCORE-1:0] r_w_count;
   logic [MAX_SCORE-1:0] r_l_count;
   logic                 r_gameover;
   logic [1:0]           r_who;

   logic [SIZE-1:0]      w_step;
   logic [SIZE-1:0]      w_next;
   logic                 w_changed;
   logic                 w_hit_win;
   logic                 w_hit_lose;
   logic                 w_w_full;
   logic                 w_l_full;

   always_comb begin
      w_step    = control[0] ? SIZE'(2) : SIZE'(1);
      w_next    = control[1] ? (r_count - w_step) : (r_count + w_step);
      w_changed = (w_next != r_count);
      // The new direction equals ~control[1], so an up-step can only ever
      // hit the win target and a down-step only the lose target; wraps past
      // the opposite target therefore never fire.
      w_hit_win  = ~control[1] & w_changed & (w_next == C_TOP);
      w_hit_lose =  control[1] & w_changed & (w_next == '0);
      w_w_full   = (r_w_count == S_TOP);
      w_l_full   = (r_l_count == S_TOP);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count    <= '0;
         r_dir      <= 1'b0;
         r_winner   <= 1'b0;
         r_loser    <= 1'b0;
         r_w_count  <= '0;
         r_l_count  <= '0;
         r_gameover <= 1'b0;
         r_who      <= 2'b00;
      end else if (r_gameover) begin
         // Auto-restart beats a load; WHO keeps the result of this game.
         r_count    <= '0;
         r_dir      <= 1'b0;
         r_winner   <= 1'b0;
         r_loser    <= 1'b0;
         r_w_count  <= '0;
         r_l_count  <= '0;
         r_gameover <= 1'b0;
      end else begin
         if (INIT_c) begin
            r_count <= INIT_l;
         end else begin
            r_count <= w_next;
            r_dir   <= ~control[1];
         end
         r_winner <= ~INIT_c & w_hit_win;
         r_loser  <= ~INIT_c & w_hit_lose;
         if (r_winner && !w_w_full) begin
            r_w_count <= r_w_count + MAX_SCORE'(1);
         end
         if (r_loser && !w_l_full) begin
            r_l_count <= r_l_count + MAX_SCORE'(1);
         end
         r_gameover <= w_w_full | w_l_full;
         if (w_w_full || w_l_full) begin
            r_who <= {w_l_full, w_w_full};
         end
      end
   end

   assign count     = r_count;
   assign direction = r_dir;
   assign WINNER    = r_winner;
   assign LOSER     = r_loser;
   assign w_count   = r_w_count;
   assign l_count   = r_l_count;
   assign GAMEOVER  = r_gameover;
   assign WHO       = r_who;

endmodule

// File: tb/tb_counter_game.sv
// tb/tb_counter_game.sv - directed self-checking bench for counter_game

module tb_counter_game;

   logic       clk;
   logic       reset;
   logic       INIT_c;
   logic [3:0] INIT_l;
   logic [1:0] control;
   logic [3:0] count;
   logic       direction;
   logic       WINNER;
   logic       LOSER;
   logic [3:0] w_count;
   logic [3:0] l_count;
   logic       GAMEOVER;
   logic [1:0] WHO;

   int errors = 0;
   int checks = 0;
   int wins;
   int losses;
   int overs;
   int both;

   counter_game #(.SIZE(4), .MAX_SCORE(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .INIT_c    (INIT_c),
      .INIT_l    (INIT_l),
      .control   (control),
      .count     (count),
      .direction (direction),
      .WINNER    (WINNER),
      .LOSER     (LOSER),
      .w_count   (w_count),
      .l_count   (l_count),
      .GAMEOVER  (GAMEOVER),
      .WHO       (WHO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".count"}, 32'(count), 0);
      check({tag, ".dir"}, 32'(direction), 0);
      check({tag, ".win"}, 32'(WINNER), 0);
      check({tag, ".lose"}, 32'(LOSER), 0);
      check({tag, ".wcnt"}, 32'(w_count), 0);
      check({tag, ".lcnt"}, 32'(l_count), 0);
      check({tag, ".over"}, 32'(GAMEOVER), 0);
      check({tag, ".who"}, 32'(WHO), 0);
   endtask

   initial begin
      reset   = 1'b0;
      INIT_c  = 1'b1;
      INIT_l  = 4'd9;
      control = 2'b00;
      tick();
      tick();
      check_all_zero("reset");

      // Count up from reset: 15 edges to the win target, then a silent wrap.
      reset  = 1'b1;
      INIT_c = 1'b0;
      tick();
      check("up1.count", 32'(count), 1);
      check("up1.lose", 32'(LOSER), 0);
      for (int i = 2; i <= 14; i++) tick();
      check("up14.count", 32'(count), 14);
      check("up14.win", 32'(WINNER), 0);
      tick();
      check("up15.count", 32'(count), 15);
      check("up15.win", 32'(WINNER), 1);
      check("up15.dir", 32'(direction), 1);
      tick();
      check("wrap.count", 32'(count), 0);
      check("wrap.win", 32'(WINNER), 0);
      check("wrap.lose", 32'(LOSER), 0);
      check("wrap.wcnt", 32'(w_count), 1);

      // Load 8, then count down to 0.
      INIT_c = 1'b1;
      INIT_l = 4'd8;
      control = 2'b10;
      tick();
      check("ld8.count", 32'(count), 8);
      check("ld8.dir", 32'(direction), 1);
      INIT_c = 1'b0;
      for (int v = 7; v >= 1; v--) begin
         tick();
         check("down.count", 32'(count), 32'(v));
         check("down.lose", 32'(LOSER), 0);
      end
      tick();
      check("down0.count", 32'(count), 0);
      check("down0.lose", 32'(LOSER), 1);
      check("down0.dir", 32'(direction), 0);
      tick();
      check("dwrap.count", 32'(count), 15);
      check("dwrap.lose", 32'(LOSER), 0);
      check("dwrap.win", 32'(WINNER), 0);
      check("dwrap.lcnt", 32'(l_count), 1);

      // Step 2 from 0 skips 15 entirely.
      INIT_c = 1'b1;
      INIT_l = 4'd0;
      control = 2'b01;
      tick();
      check("ld0.count", 32'(count), 0);
      check("ld0.lose", 32'(LOSER), 0);
      INIT_c = 1'b0;
      wins = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("even.count", 32'(count), 32'((2 * i) % 16));
         if (WINNER) wins++;
      end
      check("even.wins", 32'(wins), 0);
      check("even.lose", 32'(LOSER), 0);

      // Load 13, step 2 lands exactly on 15.
      INIT_c = 1'b1;
      INIT_l = 4'd13;
      tick();
      check("ld13.count", 32'(count), 13);
      check("ld13.win", 32'(WINNER), 0);
      INIT_c = 1'b0;
      tick();
      check("s2win.count", 32'(count), 15);
      check("s2win.win", 32'(WINNER), 1);
      tick();
      check("s2next.count", 32'(count), 1);
      check("s2next.win", 32'(WINNER), 0);
      check("s2next.wcnt", 32'(w_count), 2);

      // Loading the win target is not a win.
      INIT_c = 1'b1;
      INIT_l = 4'd15;
      control = 2'b00;
      tick();
      check("ld15.count", 32'(count), 15);
      check("ld15.win", 32'(WINNER), 0);
      INIT_c = 1'b0;

      // Fifteen full win cycles from a clean reset.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      wins = 0;
      overs = 0;
      both = 0;
      for (int i = 1; i <= 240; i++) begin
         tick();
         if (WINNER) wins++;
         if (GAMEOVER) overs++;
         if (WINNER && LOSER) both++;
      end
      check("go.wins", 32'(wins), 15);
      check("go.early", 32'(overs), 0);
      check("go.both", 32'(both), 0);
      check("go.wcnt", 32'(w_count), 15);
      check("go.count", 32'(count), 0);
      tick();
      check("go.over", 32'(GAMEOVER), 1);
      check("go.who", 32'(WHO), 1);
      check("go.count1", 32'(count), 1);
      INIT_c = 1'b1;
      INIT_l = 4'd9;
      tick();
      check("rst.over", 32'(GAMEOVER), 0);
      check("rst.count", 32'(count), 0);
      check("rst.wcnt", 32'(w_count), 0);
      check("rst.dir", 32'(direction), 0);
      check("rst.who", 32'(WHO), 1);
      INIT_c = 1'b0;

      // Build a score of 5, then reset mid-game.
      for (int i = 1; i <= 80; i++) tick();
      check("mid.wcnt", 32'(w_count), 5);
      check("mid.who", 32'(WHO), 1);
      reset = 1'b0;
      control = 2'b01;
      tick();
      check_all_zero("midrst");

      // Fifteen losses fill the lose score.
      reset = 1'b1;
      control = 2'b10;
      losses = 0;
      wins = 0;
      for (int i = 1; i <= 240; i++) begin
         tick();
         if (LOSER) losses++;
         if (WINNER) wins++;
      end
      check("lo.losses", 32'(losses), 15);
      check("lo.wins", 32'(wins), 0);
      check("lo.lcnt", 32'(l_count), 14);
      tick();
      check("lo.lfull", 32'(l_count), 15);
      check("lo.nover", 32'(GAMEOVER), 0);
      tick();
      check("lo.over", 32'(GAMEOVER), 1);
      check("lo.who", 32'(WHO), 2);
      tick();
      check("lo.clr", 32'(l_count), 0);
      check("lo.clrover", 32'(GAMEOVER), 0);
      check("lo.keepwho", 32'(WHO), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
